// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage BTB branch predictor.
// 2-bit direction counter encoding, reset/allocation states, default table size.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_t;

    localparam bp_state_t BP_INIT_STATE      = WNT;
    localparam bp_state_t BP_ALLOC_STATE     = WT;
    localparam int        BP_DEFAULT_ENTRIES = 16;

endpackage

// File: rtl/sat_counter_2b.sv
// Next-state function of a 2-bit saturating direction counter.
// Purely combinational, zero latency; no flow control.
module sat_counter_2b
    import branch_predictor_pkg::*;
(
    input  bp_state_t state_i,
    input  logic      taken_i,
    output bp_state_t state_o
);

    always_comb begin
        state_o = state_i;
        unique case (state_i)
            SNT: state_o = taken_i ? WNT : SNT;
            WNT: state_o = taken_i ? WT  : SNT;
            WT:  state_o = taken_i ? ST  : WNT;
            ST:  state_o = taken_i ? ST  : WT;
            default: state_o = BP_INIT_STATE;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on PC_F, trained from Execute
// on the next rising edge; never stalls. BP_STATS_EN adds branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = BP_DEFAULT_ENTRIES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_F,
    output logic        Predict_Taken_F,
    output logic [31:0] Predict_Target_F,
    input  logic        Branch_E,
    input  logic        Branch_Taken_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] Target_E
`ifdef BP_STATS_EN
    ,
    output logic [31:0] Branch_Count,
    output logic [31:0] Mispredict_Count
`endif
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Kept as flops (not RAM) so reset can clear every entry at once.
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [31:0]            target_d [BTB_ENTRIES];
    bp_state_t              cnt_q    [BTB_ENTRIES];
    bp_state_t              cnt_d    [BTB_ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    bp_state_t        e_cnt;
    bp_state_t        e_cnt_next;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PC_F[1:0], PC_E[1:0]};

    assign f_idx = PC_F[IDX_W+1:2];
    assign f_tag = PC_F[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    // Reads the pre-update table: a same-cycle write to this index shows up next cycle.
    assign Predict_Taken_F  = f_hit && cnt_q[f_idx][1];
    assign Predict_Target_F = f_hit ? target_q[f_idx] : 32'd0;

    assign e_idx = PC_E[IDX_W+1:2];
    assign e_tag = PC_E[31:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_cnt = cnt_q[e_idx];

    sat_counter_2b u_sat (
        .state_i (e_cnt),
        .taken_i (Branch_Taken_E),
        .state_o (e_cnt_next)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (Branch_E) begin
            if (e_hit) begin
                cnt_d[e_idx] = e_cnt_next;
                // Refreshing the target on every taken hit tracks moving JALR targets.
                if (Branch_Taken_E) begin
                    target_d[e_idx] = Target_E;
                end
            end else if (Branch_Taken_E) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = Target_E;
                cnt_d[e_idx]    = BP_ALLOC_STATE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= BP_INIT_STATE;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;
    logic        e_pred;

    // What fetch would have predicted for this instruction, recomputed from the current table.
    assign e_pred = e_hit && e_cnt[1];

    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (Branch_E) begin
            branch_count_d = branch_count_q + 32'd1;
            if (e_pred != Branch_Taken_E) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign Branch_Count     = branch_count_q;
    assign Mispredict_Count = mispred_count_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Produces Predict_Taken_F / Predict_Target_F for next-PC selection. The datapath carries Predict_Taken down the pipe to Execute, where the hazard unit compares it against Branch_Taken_E to flush on mispredict.
- Trained by the resolved branch/jump in Execute.

Parameters:
- BTB_ENTRIES, 16, number of entries; power of 2, >= 2.
- IDX_W, $clog2(BTB_ENTRIES), localparam; index width.
- TAG_W, 30-IDX_W, localparam; tag = PC[31:IDX_W+2].

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- PC_F  in  32  fetch PC (word aligned)
- Predict_Taken_F  out  1  fetch instruction predicted taken
- Predict_Target_F  out  32  predicted target; valid only when Predict_Taken_F=1
- Branch_E  in  1  Execute holds a valid branch/JAL/JALR (0 for bubbles and flushed slots)
- Branch_Taken_E  in  1  resolved direction (1 for jumps)
- PC_E  in  32  PC of the Execute instruction
- Target_E  in  32  resolved target of the Execute instruction

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), counter (2b: SNT=00, WNT=01, WT=10, ST=11).
- Reset (async, RST=1): all valid=0, counters=WNT, targets=0, tags=0. Predict_Taken_F=0 and Predict_Target_F=0 during and after reset until first allocation.
- Lookup is combinational, zero latency:
  - idx=PC_F[IDX_W+1:2].
  - hit = valid[idx] && tag[idx]==PC_F[31:IDX_W+2].
  - Predict_Taken_F = hit && counter[idx][1].
  - Predict_Target_F = hit ? target[idx] : 0.
- Update is registered on the rising CLK edge when Branch_E=1; uidx/utag are taken from PC_E.
  - Hit, taken: counter saturating +1 (ST stays ST); target<=Target_E, which covers changed JALR targets.
  - Hit, not taken: counter saturating -1 (SNT stays SNT); target unchanged.
  - Miss, taken: allocate/replace; valid<=1, tag<=utag, target<=Target_E, counter<=WT.
  - Miss, not taken: no change; no allocation for not-taken.
  - Branch_E=0: no state change.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new value is visible the cycle after the edge.
- Aliasing: a tag mismatch on the same index is a miss. Replacement on taken overwrites the old entry unconditionally.
- Stalls: no stall input. Lookup is pure on PC_F, and the pipeline guarantees one Branch_E pulse per resolved instruction (a stalled instruction is not re-presented in E).
- Mispredict flush does not suppress the update: the E instruction is the resolver and is always trained.
- Reset mid-operation: immediately clears all valids; any update at the same edge is discarded (reset dominates).
- PC_F[1:0] and PC_E[1:0] are ignored.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs Branch_Count[31:0] and Mispredict_Count[31:0], both reset to 0.
  - Branch_Count increments on each edge with Branch_E=1.
  - Mispredict_Count increments when Branch_E=1 and the prediction made for that instruction ≠ Branch_Taken_E. The prediction is recomputed at E from the current table state using PC_E, with hit && counter[1].
  - Both counters wrap modulo 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared definitions package:
  - bp_state_t enum (SNT, WNT, WT, ST).
  - BP_INIT_STATE=WNT and BP_ALLOC_STATE=WT constants.
  - Default BTB_ENTRIES constant.
- One sub-module, sat_counter_2b: combinational next-state function (state, taken -> next state, saturating). It is instantiated for the update path.
- Arrays live in branch_predictor as flops, with no RAM inference because of the async clear.

Test Plan:
- Reset then PC_F=0x100 -> Predict_Taken_F=0, Predict_Target_F=0.
- Branch_E=1, PC_E=0x100, Taken=1, Target_E=0x200; next cycle PC_F=0x100 -> Predict_Taken_F=1, Predict_Target_F=0x200 (counter WT).
- Same branch: not-taken x1 -> predict 0 (WNT); taken x3 -> ST; not-taken x1 -> still predict 1 (WT). Counter saturates at SNT after 4 further not-taken.
- Alias, BTB_ENTRIES=16: after 0x100 is allocated, a taken update at PC_E=0x140 (same idx, different tag) with Target_E=0x300 -> PC_F=0x100 misses (0), PC_F=0x140 predicts 0x300.
- Same-cycle read/write at idx of 0x100 -> that cycle's output shows old entry; the new value appears the next cycle. Assert RST mid-stream -> all predictions 0 immediately; a concurrent update is lost.
- BP_STATS_EN: 10 branches with 3 mispredicts -> Branch_Count=10, Mispredict_Count=3. Preload 0xFFFFFFFF via force -> next branch wraps Branch_Count to 0.
